// File: rtl/ov7670_stream_tx.sv
// ov7670_stream_tx
// Camera emulator: reads RGB332 pixels from a framebuffer and regenerates an
// OV7670-style RGB565 byte stream (pclk = clk/2, vsync, href, 8-bit data).
// Outputs only change on the clk edge where pclk falls, so a receiver
// samples on pclk rising.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   en         start a frame from idle / chain the next frame at frame end
//   mem_addr   framebuffer read address (row-major pixel index)
//   mem_data   RGB332 pixel {R[2:0],G[2:0],B[1:0]}, valid 1 clk after mem_addr
//   pclk       pixel byte clock
//   vsync      frame sync, active high
//   href       line valid, active high
//   d          RGB565 byte stream, byte0 = {R5,G6[5:3]}, byte1 = {G6[2:0],B5}
//   busy       high from frame start to frame end
//   frame_done one-clk pulse at end of frame
//
// Optional build macro TEST_PATTERN_EN: pixels are the column index x[7:0]
// instead of mem_data; mem_addr is still driven identically.

module ov7670_stream_tx #(
   parameter int unsigned H_PIX     = 160,
   parameter int unsigned V_LINES   = 120,
   parameter int unsigned H_BLANK   = 16,
   parameter int unsigned VS_LINES  = 3,
   parameter int unsigned VBP_LINES = 10,
   parameter int unsigned ADDR_W    = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_data,
   output logic              pclk,
   output logic              vsync,
   output logic              href,
   output logic [7:0]        d,
   output logic              busy,
   output logic              frame_done
);

   localparam int unsigned LINE_P = 2*H_PIX + H_BLANK;
   localparam int unsigned VS_P   = VS_LINES*LINE_P;
   localparam int unsigned VB_P   = VBP_LINES*LINE_P;
   localparam int unsigned ACT_P  = 2*H_PIX;
   localparam int unsigned MAX_A  = (VS_P > VB_P) ? VS_P : VB_P;
   localparam int unsigned MAX_P  = (MAX_A > LINE_P) ? MAX_A : LINE_P;
   localparam int unsigned CNT_W  = $clog2(MAX_P + 1);
   localparam int unsigned LINE_W = $clog2(V_LINES + 1);
   localparam int unsigned COL_W  = $clog2(H_PIX + 1);

   localparam logic [CNT_W-1:0]  VS_END    = CNT_W'(VS_P - 1);
   localparam logic [CNT_W-1:0]  VB_END    = CNT_W'(VB_P - 1);
   localparam logic [CNT_W-1:0]  ACT_END   = CNT_W'(ACT_P - 1);
   localparam logic [CNT_W-1:0]  HB_END    = CNT_W'(H_BLANK - 1);
   localparam logic [LINE_W-1:0] NUM_LINES = LINE_W'(V_LINES);
   localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(V_LINES - 1);
   localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(H_PIX - 1);

   typedef enum logic [2:0] {
      IDLE,
      VSYNC,
      VBACK,
      ACTIVE,
      HBLANK
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;     // pclk periods spent in state (byte index in ACTIVE)
   logic [LINE_W-1:0]   line_q, line_d;   // active lines completed this frame
   logic [COL_W-1:0]    col_q, col_d;     // column of the pixel on the bus
   logic [7:0]          pix_q, pix_d;     // pixel held for byte1
   logic                pclk_d, vsync_d, href_d, busy_d, done_d;
   logic [7:0]          d_d;
   logic [ADDR_W-1:0]   addr_d;
   logic                start_frame, start_line, load_pix;
   logic [7:0]          new_pix;

   function automatic logic [7:0] hi_byte(input logic [7:0] p);
      return {p[7:5], p[7:6], p[4:2]};
   endfunction

   function automatic logic [7:0] lo_byte(input logic [7:0] p);
      return {p[4:2], p[1:0], p[1:0], p[1]};
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         line_q     <= '0;
         col_q      <= '0;
         pix_q      <= '0;
         pclk       <= 1'b0;
         vsync      <= 1'b0;
         href       <= 1'b0;
         d          <= '0;
         mem_addr   <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         line_q     <= line_d;
         col_q      <= col_d;
         pix_q      <= pix_d;
         pclk       <= pclk_d;
         vsync      <= vsync_d;
         href       <= href_d;
         d          <= d_d;
         mem_addr   <= addr_d;
         busy       <= busy_d;
         frame_done <= done_d;
      end
   end

   // Every timed decision happens when pclk_q is 1, i.e. on the edge that
   // drives pclk low. The address for the next pixel is advanced as soon as
   // the current pixel is loaded, giving the memory a full pixel period.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      line_d      = line_q;
      col_d       = col_q;
      pix_d       = pix_q;
      pclk_d      = 1'b0;
      vsync_d     = vsync;
      href_d      = href;
      d_d         = d;
      addr_d      = mem_addr;
      busy_d      = busy;
      done_d      = 1'b0;
      start_frame = 1'b0;
      start_line  = 1'b0;
      load_pix    = 1'b0;
      new_pix     = '0;

      if (state_q != IDLE) pclk_d = ~pclk;

      case (state_q)
         IDLE: begin
            if (en) start_frame = 1'b1;
         end
         VSYNC: begin
            if (pclk) begin
               if (cnt_q == VS_END) begin
                  state_d = VBACK;
                  vsync_d = 1'b0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         VBACK: begin
            if (pclk) begin
               if (cnt_q == VB_END) start_line = 1'b1;
               else                 cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ACTIVE: begin
            if (pclk) begin
               if (cnt_q == ACT_END) begin
                  state_d = HBLANK;
                  href_d  = 1'b0;
                  d_d     = '0;
                  cnt_d   = '0;
                  line_d  = line_q + LINE_W'(1);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (!cnt_q[0]) begin
                     d_d = lo_byte(pix_q);
                  end else begin
                     col_d    = col_q + COL_W'(1);
                     load_pix = 1'b1;
                  end
               end
            end
         end
         HBLANK: begin
            if (pclk) begin
               if (cnt_q == HB_END) begin
                  if (line_q < NUM_LINES) begin
                     start_line = 1'b1;
                  end else begin
                     done_d = 1'b1;
                     if (en) begin
                        start_frame = 1'b1;
                     end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                     end
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (start_line) begin
         state_d  = ACTIVE;
         href_d   = 1'b1;
         cnt_d    = '0;
         col_d    = '0;
         load_pix = 1'b1;
      end

      if (load_pix) begin
`ifdef TEST_PATTERN_EN
         new_pix = 8'(col_d);
`else
         new_pix = mem_data;
`endif
         pix_d = new_pix;
         d_d   = hi_byte(new_pix);
         // The final pixel of the frame does not advance, so the address
         // never leaves 0 .. H_PIX*V_LINES-1.
         if (!((line_q == LAST_LINE) && (col_d == LAST_COL)))
            addr_d = mem_addr + ADDR_W'(1);
      end

      if (start_frame) begin
         state_d = VSYNC;
         vsync_d = 1'b1;
         busy_d  = 1'b1;
         pclk_d  = 1'b0;
         addr_d  = '0;
         cnt_d   = '0;
         line_d  = '0;
      end
   end

endmodule

// File: tb/tb_ov7670_stream_tx.sv
// Testbench for ov7670_stream_tx with a small geometry (4x2 pixels,
// LINE_P = 10 pclk). Expected RGB565 bytes are pushed to a scoreboard queue
// when framebuffer contents are chosen and popped at each pclk rising edge
// while href is high. Control-signal traces are compared against the frame
// timing derived from the geometry.

module tb_ov7670_stream_tx;

   localparam int H_PIX     = 4;
   localparam int V_LINES   = 2;
   localparam int H_BLANK   = 2;
   localparam int VS_LINES  = 1;
   localparam int VBP_LINES = 1;
   localparam int ADDR_W    = 4;

   localparam int LINE_P   = 2*H_PIX + H_BLANK;
   localparam int VS_CLK   = 2*VS_LINES*LINE_P;
   localparam int ACT0     = 2*(VS_LINES + VBP_LINES)*LINE_P;
   localparam int LINE_CLK = 2*LINE_P;
   localparam int HREF_CLK = 4*H_PIX;
   localparam int FRAME    = ACT0 + V_LINES*LINE_CLK;
   localparam int NPIX     = H_PIX*V_LINES;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;
   logic              pclk, vsync, href, busy, frame_done;
   logic [7:0]        d;

   logic [7:0] mem [0:15];
   logic [7:0] exp_q [$];

   logic              vs_t [0:255];
   logic              hr_t [0:255];
   logic              pc_t [0:255];
   logic              bs_t [0:255];
   logic              fd_t [0:255];
   logic [7:0]        d_t  [0:255];
   logic [ADDR_W-1:0] a_t  [0:255];

   int tests = 0;
   int fails = 0;

   ov7670_stream_tx #(
      .H_PIX    (H_PIX),
      .V_LINES  (V_LINES),
      .H_BLANK  (H_BLANK),
      .VS_LINES (VS_LINES),
      .VBP_LINES(VBP_LINES),
      .ADDR_W   (ADDR_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .pclk      (pclk),
      .vsync     (vsync),
      .href      (href),
      .d         (d),
      .busy      (busy),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Synchronous-read framebuffer: data appears one clk after the address.
   always @(posedge clk) mem_data <= mem[mem_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] rgb565(input logic [7:0] p);
      logic [4:0] r5;
      logic [5:0] g6;
      logic [4:0] b5;
      r5 = {p[7:5], p[7:6]};
      g6 = {p[4:2], p[4:2]};
      b5 = {p[1:0], p[1:0], p[1]};
      return {r5, g6, b5};
   endfunction

   task automatic push_frame();
      logic [7:0]  p;
      logic [15:0] w;
      for (int k = 0; k < NPIX; k++) begin
`ifdef TEST_PATTERN_EN
         p = 8'(k % H_PIX);
`else
         p = mem[k];
`endif
         w = rgb565(p);
         exp_q.push_back(w[15:8]);
         exp_q.push_back(w[7:0]);
      end
   endtask

   task automatic capture(input int n, input int drop_at);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         vs_t[i] = vsync;
         hr_t[i] = href;
         pc_t[i] = pclk;
         bs_t[i] = busy;
         fd_t[i] = frame_done;
         d_t[i]  = d;
         a_t[i]  = mem_addr;
         if (i == drop_at) en = 1'b0;
      end
   endtask

   function automatic bit exp_href(input int o);
      int r;
      if (o < ACT0) return 1'b0;
      r = o - ACT0;
      return ((r / LINE_CLK) < V_LINES) && ((r % LINE_CLK) < HREF_CLK);
   endfunction

   task automatic check_trace(input string tag, input int n, input bit cont);
      int  mv, mh, mp, mb, mf, md, vs_hi, under, o;
      bit  in_frame, ev, eh, ep, ef;
      logic [7:0] e;
      mv = 0; mh = 0; mp = 0; mb = 0; mf = 0; md = 0; vs_hi = 0; under = 0;
      for (int i = 0; i < n; i++) begin
         in_frame = cont || (i < FRAME);
         o  = i % FRAME;
         ev = in_frame && (o < VS_CLK);
         eh = in_frame && exp_href(o);
         ep = in_frame && o[0];
         ef = (i > 0) && (o == 0) && (cont || (i == FRAME));
         if (vs_t[i] !== ev)       mv++;
         if (hr_t[i] !== eh)       mh++;
         if (pc_t[i] !== ep)       mp++;
         if (bs_t[i] !== in_frame) mb++;
         if (fd_t[i] !== ef)       mf++;
         if (vs_t[i] === 1'b1 && i < FRAME) vs_hi++;
         if (hr_t[i] !== 1'b1 && d_t[i] !== 8'h00) md++;
         if (i > 0 && hr_t[i] === 1'b1 && pc_t[i] === 1'b1 && pc_t[i-1] === 1'b0) begin
            if (exp_q.size() == 0) begin
               under++;
            end else begin
               e = exp_q.pop_front();
               check($sformatf("%s_byte@%0d", tag, i), d_t[i], e);
            end
         end
      end
      check({tag, "_vsync_trace_errs"}, mv, 0);
      check({tag, "_href_trace_errs"}, mh, 0);
      check({tag, "_pclk_trace_errs"}, mp, 0);
      check({tag, "_busy_trace_errs"}, mb, 0);
      check({tag, "_done_trace_errs"}, mf, 0);
      check({tag, "_d_nonzero_blank"}, md, 0);
      check({tag, "_vsync_high_clks"}, vs_hi, VS_CLK);
      check({tag, "_sb_underflow"}, under, 0);
      check({tag, "_sb_left"}, exp_q.size(), 0);
   endtask

   initial begin
      logic [ADDR_W-1:0] seq [$];

      rst = 1'b0;
      en  = 1'b0;
      for (int k = 0; k < 16; k++) mem[k] = 8'h00;
      mem[0] = 8'hE0; mem[1] = 8'h1C; mem[2] = 8'h03; mem[3] = 8'h92;
      mem[4] = 8'h00; mem[5] = 8'hFF; mem[6] = 8'h5A; mem[7] = 8'hA5;

      // Reset state
      #12;
      check("rst_ctrl", {pclk, vsync, href, busy, frame_done}, 5'b0);
      check("rst_d", d, 8'h00);
      check("rst_addr", mem_addr, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("idle_pclk", pclk, 1'b0);

      // Single frame: en pulsed, then low for the rest of the frame
      push_frame();
      en = 1'b1;
      capture(FRAME + 6, 0);
      check_trace("single", FRAME + 6, 1'b0);

      // Back-to-back frames with en held high
      for (int k = 0; k < NPIX; k++) mem[k] = 8'($urandom_range(0, 255));
      push_frame();
      push_frame();
      en = 1'b1;
      capture(2*FRAME, -1);
      check_trace("chain", 2*FRAME, 1'b1);
      seq.push_back(a_t[0]);
      for (int i = 1; i < FRAME; i++)
         if (a_t[i] !== a_t[i-1]) seq.push_back(a_t[i]);
      check("addr_count", seq.size(), NPIX);
      for (int k = 0; k < NPIX; k++)
         if (k < seq.size()) check($sformatf("addr_seq%0d", k), seq[k], k);
      check("addr_frame2", a_t[FRAME], 0);

      // Asynchronous reset during the second active line of frame 3
      repeat (ACT0 + LINE_CLK + 6) @(negedge clk);
      check("href_before_rst", href, 1'b1);
      en = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("arst_ctrl", {pclk, vsync, href, busy, frame_done}, 5'b0);
      check("arst_d", d, 8'h00);
      check("arst_addr", mem_addr, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_idle", {pclk, vsync, busy}, 3'b0);

      // Restart after reset: full frame from vsync, address 0
      for (int k = 0; k < NPIX; k++) mem[k] = 8'($urandom_range(0, 255));
      push_frame();
      en = 1'b1;
      capture(FRAME + 6, 0);
      check("restart_addr0", a_t[0], 0);
      check_trace("restart", FRAME + 6, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
